// File: rtl/mem_arbiter.sv
// Registered req/ack arbiter sharing one memory port among NUM_REQ requesters.
// Round-robin or fixed-priority selection, one transaction in flight, optional timeout.
module mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        ack_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic                      mem_ack_i,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic [1:0]                grant_id_o,
  output logic                      busy_o
);

  // state | meaning
  // IDLE  | no transaction; arbitrate on any request
  // BUSY  | mem_req high, waiting for mem_ack or timeout
  // RESP  | ack/err pulse to the granted requester
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                win_vld;
  logic [1:0]          win_idx;

  // Round-robin starts the search just past the last grant
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    if (RR_EN != 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!win_vld && req_i[(int'(grant_q) + k) % NUM_REQ]) begin
          win_vld = 1'b1;
          win_idx = 2'((int'(grant_q) + k) % NUM_REQ);
        end
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_vld && req_i[i]) begin
          win_vld = 1'b1;
          win_idx = 2'(i);
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d     = BUSY;
          grant_d     = win_idx;
          mem_req_d   = 1'b1;
          mem_we_d    = req_we_i[win_idx];
          mem_addr_d  = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_wdata_d = req_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
          cnt_d       = '0;
        end
      end
      BUSY: begin
        if (mem_req_q && mem_ack_i) begin
          rdata_d        = mem_rdata_i;
          ack_d[grant_q] = 1'b1;
          mem_req_d      = 1'b0;
          state_d        = RESP;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d        = '1;
          ack_d[grant_q] = 1'b1;
          err_d[grant_q] = 1'b1;
          mem_req_d      = 1'b0;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      grant_q     <= 2'(NUM_REQ - 1);
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin instance (TIMEOUT=8) and a
// fixed-priority instance, stepped in lockstep from one initial block.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req, req_we;
  logic [95:0] req_addr, req_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [2:0]  ack, err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  grant_id;
  logic        busy;

  logic [2:0]  fp_req;
  logic        fp_mem_ack;
  logic [2:0]  fp_ack, fp_err;
  logic [31:0] fp_rdata, fp_mem_addr, fp_mem_wdata;
  logic        fp_mem_req, fp_mem_we, fp_busy;
  logic [1:0]  fp_grant_id;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT(8)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .ack_o(ack), .err_o(err),
    .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .grant_id_o(grant_id), .busy_o(busy)
  );

  mem_arbiter #(.NUM_REQ(3), .ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT(8)) u_fp (
    .clk_i(clk), .rst_ni(rst_n), .req_i(fp_req), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .ack_o(fp_ack), .err_o(fp_err),
    .rdata_o(fp_rdata), .mem_req_o(fp_mem_req), .mem_we_o(fp_mem_we), .mem_addr_o(fp_mem_addr),
    .mem_wdata_o(fp_mem_wdata), .mem_ack_i(fp_mem_ack), .mem_rdata_i(mem_rdata),
    .grant_id_o(fp_grant_id), .busy_o(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic [1:0] rr_order [6];
    rr_order = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

    rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; fp_req = '0; fp_mem_ack = 1'b0;
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 2);
    rst_n = 1'b1;
    tick();

    // single read
    req = 3'b001; req_addr[0 +: 32] = 32'h100; req_we = 3'b000;
    tick();
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_grant", grant_id, 0);
    chk("rd_busy", busy, 1);
    tick();
    chk("rd_no_early_ack", ack, 0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    chk("rd_ack", ack, 3'b001);
    chk("rd_rdata", rdata, 32'hCAFEF00D);
    chk("rd_err", err, 0);
    chk("rd_mem_req_drop", mem_req, 0);
    mem_ack = 1'b0; req = '0;
    tick();
    chk("rd_ack_clear", ack, 0);
    chk("rd_idle", busy, 0);

    // round-robin fairness with all requesters active
    req_addr[0 +: 32] = 32'hA0; req_addr[32 +: 32] = 32'hA1; req_addr[64 +: 32] = 32'hA2;
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_grant", grant_id, rr_order[i]);
      chk("rr_addr", mem_addr, 32'hA0 + rr_order[i]);
      mem_ack = 1'b1; mem_rdata = 32'h5000 + i;
      tick();
      chk("rr_ack", ack, 3'b001 << rr_order[i]);
      chk("rr_rdata", rdata, 32'h5000 + i);
      mem_ack = 1'b0;
      tick();
      chk("rr_ack_pulse", ack, 0);
      chk("rr_idle_gap", busy, 0);
    end
    req = '0;
    tick();

    // mem_ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    chk("idle_ack_none", ack, 0);
    chk("idle_busy", busy, 0);
    chk("idle_mem_req", mem_req, 0);
    mem_ack = 1'b0;

    // req dropped and address changed while granted
    req = 3'b010; req_we = 3'b010; req_addr[32 +: 32] = 32'h200; req_wdata[32 +: 32] = 32'h1111;
    tick();
    chk("hold_grant", grant_id, 1);
    chk("hold_we", mem_we, 1);
    chk("hold_addr0", mem_addr, 32'h200);
    req = '0; req_addr[32 +: 32] = 32'h300; req_wdata[32 +: 32] = 32'h2222;
    tick();
    chk("hold_addr", mem_addr, 32'h200);
    chk("hold_wdata", mem_wdata, 32'h1111);
    chk("hold_mem_req", mem_req, 1);
    mem_ack = 1'b1;
    tick();
    chk("drop_ack", ack, 3'b010);
    chk("drop_err", err, 0);
    mem_ack = 1'b0;
    tick();

    // timeout: memory never answers
    req = 3'b010; req_addr[32 +: 32] = 32'h400;
    tick();
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("to_mem_req_cycles", n, 8);
    chk("to_ack", ack, 3'b010);
    chk("to_err", err, 3'b010);
    chk("to_rdata", rdata, 32'hFFFFFFFF);
    req = '0;
    tick();
    chk("to_ack_clear", ack, 0);
    chk("to_err_clear", err, 0);
    chk("to_idle", busy, 0);

    // mem_ack on the final allowed cycle beats the timeout
    req = 3'b010;
    tick();
    repeat (7) tick();
    chk("to8_no_early", ack, 0);
    chk("to8_mem_req", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    tick();
    chk("to8_ack", ack, 3'b010);
    chk("to8_err", err, 0);
    chk("to8_rdata", rdata, 32'h12345678);
    mem_ack = 1'b0; req = '0;
    tick();

    // reset in the middle of a transaction
    req = 3'b111;
    tick();
    chk("mr_grant", grant_id, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_mem_req_async", mem_req, 0);
    chk("mr_busy", busy, 0);
    mem_ack = 1'b1;
    tick();
    chk("mr_no_ack", ack, 0);
    mem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("mr_first_grant", grant_id, 0);
    chk("mr_mem_req", mem_req, 1);
    mem_ack = 1'b1;
    tick();
    chk("mr_ack", ack, 3'b001);
    mem_ack = 1'b0; req = '0;
    tick();
    tick();

    // fixed priority: requester 0 starves requester 2
    fp_req = 3'b101;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fp_grant", fp_grant_id, 0);
      fp_mem_ack = 1'b1;
      tick();
      chk("fp_ack", fp_ack, 3'b001);
      fp_mem_ack = 1'b0;
      tick();
    end
    fp_req = 3'b100;
    tick();
    chk("fp_grant2", fp_grant_id, 2);
    chk("fp_mem_req", fp_mem_req, 1);
    fp_mem_ack = 1'b1;
    tick();
    chk("fp_ack2", fp_ack, 3'b100);
    fp_mem_ack = 1'b0; fp_req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single CPU memory port between N requesters: index 0 = execute, 1 = dcache, 2 = fetch.
- Replaces the fixed-priority combinational data mux in the CPU top level with a registered req/ack arbiter.
- Arbitration is round-robin, or fixed priority when configured, and has a per-transaction timeout.
- One transaction is in flight at a time.

Parameters:
- NUM_REQ, 3: number of requesters (2..4).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- RR_EN, 1: 1 = round-robin; 0 = fixed priority, lowest index wins.
- TIMEOUT, 255: maximum BUSY cycles waiting for mem_ack. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_we  in  NUM_REQ  per-requester write enable.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- ack  out  NUM_REQ  one-cycle completion pulse per requester.
- err  out  NUM_REQ  one-cycle timeout flag; asserted together with ack.
- rdata  out  DATA_W  read data, valid while any ack bit is high.
- mem_req  out  1  memory request level.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion pulse; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_W  memory read data.
- grant_id  out  2  index of the current or last granted requester.
- busy  out  1  high in BUSY and RESP states.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - ack=0, err=0, rdata=0, busy=0.
  - grant_id=NUM_REQ-1, so requester 0 has top round-robin priority after reset.
  - Timeout counter=0.
  - Reset mid-transaction abandons it: no ack is issued, and mem_req drops asynchronously.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If req is nonzero, select a winner and go to BUSY.
  - Round-robin: search indices grant_id+1, grant_id+2, ... modulo NUM_REQ; the first one with req high wins.
  - Fixed priority: the lowest index with req high wins.
  - On that edge, register grant_id=winner, mem_req=1, and latch mem_addr, mem_wdata, mem_we from the winner's slice. Clear the counter.
  - Latency: req sampled at edge N gives mem_req=1 after edge N.
- BUSY:
  - mem_ack is honoured only when mem_req=1.
  - On mem_ack: register rdata=mem_rdata (write transactions also register it; the value is don't-care), set ack[grant_id]=1, drop mem_req, go to RESP.
  - Otherwise increment the counter. When TIMEOUT is nonzero and the counter reaches TIMEOUT-1 without mem_ack:
    - set ack[grant_id]=1 and err[grant_id]=1;
    - set rdata to all ones;
    - drop mem_req and go to RESP.
  - mem_ack in the same cycle as the timeout edge takes precedence: normal ack, err=0.
- RESP:
  - ack and err are high for exactly this one cycle, then clear.
  - Go to IDLE. No arbitration happens in RESP.
  - The minimum gap between consecutive grants is therefore one IDLE cycle.
- Requester rules:
  - Hold req, req_we, req_addr and req_wdata stable from assertion until ack is seen.
  - Deassert req in the cycle after ack, or the requester is re-arbitrated as a new request.
  - Deasserting req while granted does not abort: the transaction completes and ack still pulses.
- The memory port holds mem_addr, mem_wdata and mem_we stable while mem_req=1.
- A mem_ack arriving in IDLE or RESP is ignored.
- Only one bit of ack is ever high at a time.
- grant_id holds its value after completion; round-robin rotation uses it.
- The counter width is the minimum width that holds TIMEOUT.

Test Plan:
- Single read: req=3'b001, addr0=0x100; memory answers mem_ack with rdata 0xCAFEF00D 2 cycles after mem_req -> mem_req rises 1 cycle after req with mem_addr=0x100, we=0; ack=3'b001 for one cycle with rdata=0xCAFEF00D; err=0.
- Round-robin fairness: all three req held high, mem_ack after 1 cycle each -> grant order 0,1,2,0,1,2; every ack is a single-cycle pulse; one IDLE cycle between grants.
- Fixed priority (RR_EN=0): req0 and req2 held high continuously -> only requester 0 is granted over 6 transactions. Then drop req0 -> requester 2 is granted next.
- Timeout (TIMEOUT=8): write request from requester 1 and memory never acks -> mem_req is high for exactly 8 cycles; ack[1]=1, err[1]=1, rdata=0xFFFFFFFF; FSM returns to IDLE. Repeat with mem_ack on cycle 8 -> err=0.
- Reset mid-transaction: reset=0 while BUSY -> mem_req=0 immediately, no ack; after release with req=3'b111 -> first grant_id=0.
- Protocol edges:
  - Requester drops req during BUSY -> ack is still issued.
  - mem_ack pulsed while IDLE -> no ack, state unchanged.
  - mem_addr and mem_wdata stay constant while req_addr changes during BUSY.
